// File: rtl/note_player_pkg.sv
// Shared song-player definitions: FSM encodings, widths and square-wave amplitude.
// Also imported by the upstream song sequencer.
package note_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } player_state_t;

  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;
  localparam int ACC_W    = 20;
  localparam int SAMPLE_W = 16;

  localparam logic signed [SAMPLE_W-1:0] AMPLITUDE = 16'sh3FFF;

  // Square wave: positive half while the phase MSB is clear.
  function automatic logic signed [SAMPLE_W-1:0] square_sample(input logic phase_msb);
    return phase_msb ? -AMPLITUDE : AMPLITUDE;
  endfunction

endpackage

// File: rtl/dffr.sv
// Reset flop primitive, width W, synchronous active-high reset to zero.
// Latency 1 cycle; no flow control.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/frequency_rom.sv
// Note index to 20-bit phase step (note 0 = rest = step 0), equal-tempered, six octaves.
// Registered output, 1-cycle latency; no flow control.
module frequency_rom
  import note_player_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note,
  output logic [ACC_W-1:0]  step_size
);

  logic [NOTE_W-1:0] idx;
  logic [NOTE_W-1:0] octave;
  logic [NOTE_W-1:0] semi;
  logic [ACC_W-1:0]  base;
  logic [ACC_W-1:0]  step_d;

  assign idx    = note - 6'd1;
  assign octave = idx / 6'd12;
  assign semi   = idx % 6'd12;

  // Lowest octave, semitone ratios of 2^(1/12) from 0x4000; higher octaves shift left.
  always_comb begin
    base = 20'h04000;
    case (semi)
      6'd0:  base = 20'h04000;
      6'd1:  base = 20'h043CE;
      6'd2:  base = 20'h047D6;
      6'd3:  base = 20'h04C1C;
      6'd4:  base = 20'h050A3;
      6'd5:  base = 20'h0556E;
      6'd6:  base = 20'h05A83;
      6'd7:  base = 20'h05FE4;
      6'd8:  base = 20'h06598;
      6'd9:  base = 20'h06BA2;
      6'd10: base = 20'h07209;
      6'd11: base = 20'h078D1;
      default: base = 20'h04000;
    endcase
  end

  assign step_d = (note == '0) ? '0 : (base << octave);

  dffr #(.W(ACC_W)) u_step (.clk(clk), .reset(reset), .d(step_d), .q(step_size));

endmodule

// File: rtl/note_player.sv
// Plays one note at a time as a square wave; IDLE->LOAD->PLAY->DONE, sample 1 cycle after request.
// Upstream waits on player_ready (IDLE only); offers while busy are dropped, not queued.
module note_player
  import note_player_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play,
  input  logic                       beat,
  input  logic                       new_note,
  input  logic [NOTE_W-1:0]          note,
  input  logic [DUR_W-1:0]           duration,
  input  logic                       generate_next_sample,
  output logic                       player_ready,
  output logic                       note_done,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_ready
);

  logic [1:0]                 state_bits;
  logic [1:0]                 state_d_bits;
  player_state_t              state;
  player_state_t              state_d;
  logic [NOTE_W-1:0]          note_q, note_d;
  logic [DUR_W-1:0]           cnt_q, cnt_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [ACC_W-1:0]           step_size;
  logic                       capture, beat_en, phase_en, note_done_d;
  logic signed [SAMPLE_W-1:0] sample_d;

  assign state        = player_state_t'(state_bits);
  assign player_ready = (state == ST_IDLE);
  assign capture      = new_note & player_ready;
  assign beat_en      = beat & play & (state == ST_PLAY) & (cnt_q != '0);
  assign phase_en     = generate_next_sample & play & (state == ST_PLAY);

  always_comb begin
    state_d = state;
    note_d  = note_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (capture) begin
      note_d = note;
      cnt_d  = duration;
      acc_d  = '0;
    end
    if (beat_en)  cnt_d = cnt_q - 6'd1;
    if (phase_en) acc_d = acc_q + step_size;
    case (state)
      ST_IDLE: if (capture) state_d = ST_LOAD;
      // LOAD gives the step ROM its cycle; a zero-length note skips PLAY.
      ST_LOAD: state_d = (cnt_q == '0) ? ST_DONE : ST_PLAY;
      ST_PLAY: if (beat_en && cnt_q == 6'd1) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_d_bits = state_d;
  assign note_done_d  = (state_d == ST_DONE);

  // Sample reflects the conditions at request time, so a final-beat request still sounds.
  always_comb begin
    sample_d = '0;
    if (phase_en && note_q != '0) sample_d = square_sample(acc_d[ACC_W-1]);
  end

  frequency_rom u_rom (.clk(clk), .reset(reset), .note(note_q), .step_size(step_size));

  dffr #(.W(2))        u_state (.clk(clk), .reset(reset), .d(state_d_bits), .q(state_bits));
  dffr #(.W(NOTE_W))   u_note  (.clk(clk), .reset(reset), .d(note_d), .q(note_q));
  dffr #(.W(DUR_W))    u_cnt   (.clk(clk), .reset(reset), .d(cnt_d), .q(cnt_q));
  dffr #(.W(ACC_W))    u_acc   (.clk(clk), .reset(reset), .d(acc_d), .q(acc_q));
  dffr #(.W(1))        u_done  (.clk(clk), .reset(reset), .d(note_done_d), .q(note_done));
  dffr #(.W(1))        u_srdy  (.clk(clk), .reset(reset), .d(generate_next_sample), .q(sample_ready));
  dffr #(.W(SAMPLE_W)) u_sout  (.clk(clk), .reset(reset), .d(sample_d), .q(sample_out));

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: reset, timing, pause, square-wave sign, ignored offers, reset mid-note.
module tb_note_player;

  logic              clk = 1'b0;
  logic              reset, play, beat, new_note, generate_next_sample;
  logic [5:0]        note, duration;
  logic              player_ready, note_done, sample_ready;
  logic signed [15:0] sample_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] POS = 16'h3FFF;
  localparam logic [15:0] NEG = 16'hC001;

  always #5 clk = ~clk;

  note_player dut (
    .clk(clk), .reset(reset), .play(play), .beat(beat), .new_note(new_note),
    .note(note), .duration(duration), .generate_next_sample(generate_next_sample),
    .player_ready(player_ready), .note_done(note_done),
    .sample_out(sample_out), .sample_ready(sample_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [19:0] acc;
    logic [15:0] exp_s;

    reset = 1'b1; play = 1'b0; beat = 1'b0; new_note = 1'b0;
    generate_next_sample = 1'b0; note = '0; duration = '0;
    tick(); tick();
    check("rst_ready", {31'd0, player_ready}, 32'd1);
    check("rst_done",  {31'd0, note_done}, 32'd0);
    check("rst_srdy",  {31'd0, sample_ready}, 32'd0);
    check("rst_sout",  {16'd0, sample_out}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", {31'd0, player_ready}, 32'd1);

    // Basic note: note 1, two beats, first beat coincides with a sample request.
    play = 1'b1; note = 6'd1; duration = 6'd2; new_note = 1'b1;
    tick();
    new_note = 1'b0;
    check("t1_load_ready", {31'd0, player_ready}, 32'd0);
    check("t1_load_done",  {31'd0, note_done}, 32'd0);
    tick();
    check("t1_play_ready", {31'd0, player_ready}, 32'd0);
    beat = 1'b1; generate_next_sample = 1'b1;
    tick();
    beat = 1'b0; generate_next_sample = 1'b0;
    check("t1_srdy", {31'd0, sample_ready}, 32'd1);
    check("t1_sout", {16'd0, sample_out}, {16'd0, POS});
    check("t1_done_b1", {31'd0, note_done}, 32'd0);
    tick();
    check("t1_srdy_off", {31'd0, sample_ready}, 32'd0);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    check("t1_done_b2", {31'd0, note_done}, 32'd1);
    check("t1_done_ready", {31'd0, player_ready}, 32'd0);
    tick();
    check("t1_idle_done", {31'd0, note_done}, 32'd0);
    check("t1_idle_ready", {31'd0, player_ready}, 32'd1);

    // Zero duration: IDLE, LOAD, DONE, IDLE; samples silent throughout.
    note = 6'd5; duration = 6'd0; new_note = 1'b1; generate_next_sample = 1'b1;
    tick();
    new_note = 1'b0;
    check("t2_load_ready", {31'd0, player_ready}, 32'd0);
    check("t2_load_done",  {31'd0, note_done}, 32'd0);
    check("t2_load_srdy",  {31'd0, sample_ready}, 32'd1);
    check("t2_load_sout",  {16'd0, sample_out}, 32'd0);
    tick();
    check("t2_done", {31'd0, note_done}, 32'd1);
    check("t2_done_sout", {16'd0, sample_out}, 32'd0);
    tick();
    generate_next_sample = 1'b0;
    check("t2_idle_ready", {31'd0, player_ready}, 32'd1);
    check("t2_idle_done",  {31'd0, note_done}, 32'd0);
    check("t2_idle_sout",  {16'd0, sample_out}, 32'd0);

    // Pause: 10 beats and 5 requests while play=0 must not advance the note.
    note = 6'd1; duration = 6'd3; new_note = 1'b1;
    tick();
    new_note = 1'b0;
    tick();
    beat = 1'b1;
    tick();
    play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      beat = 1'b1;
      generate_next_sample = (i < 5);
      tick();
      check("t3_pause_srdy", {31'd0, sample_ready}, (i < 5) ? 32'd1 : 32'd0);
      check("t3_pause_sout", {16'd0, sample_out}, 32'd0);
      check("t3_pause_done", {31'd0, note_done}, 32'd0);
    end
    generate_next_sample = 1'b0; beat = 1'b0;
    tick();
    check("t3_pause_ready", {31'd0, player_ready}, 32'd0);
    play = 1'b1; beat = 1'b1;
    tick();
    check("t3_resume_b2", {31'd0, note_done}, 32'd0);
    tick();
    beat = 1'b0;
    check("t3_resume_b3", {31'd0, note_done}, 32'd1);
    tick();
    check("t3_idle_ready", {31'd0, player_ready}, 32'd1);

    // Half-period step: sign alternates on every request, accumulator wraps each second one.
    note = 6'd61; duration = 6'd2; new_note = 1'b1;
    tick();
    new_note = 1'b0;
    tick();
    acc = '0;
    generate_next_sample = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      acc   = acc + 20'h80000;
      exp_s = acc[19] ? NEG : POS;
      check("t4_srdy", {31'd0, sample_ready}, 32'd1);
      check("t4_sout", {16'd0, sample_out}, {16'd0, exp_s});
    end
    generate_next_sample = 1'b0;
    tick();
    check("t4_gap_srdy", {31'd0, sample_ready}, 32'd0);
    check("t4_gap_sout", {16'd0, sample_out}, 32'd0);
    beat = 1'b1;
    tick();
    generate_next_sample = 1'b1;
    tick();
    beat = 1'b0; generate_next_sample = 1'b0;
    acc   = acc + 20'h80000;
    exp_s = acc[19] ? NEG : POS;
    check("t4_final_srdy", {31'd0, sample_ready}, 32'd1);
    check("t4_final_sout", {16'd0, sample_out}, {16'd0, exp_s});
    check("t4_final_done", {31'd0, note_done}, 32'd1);
    tick();
    check("t4_idle_ready", {31'd0, player_ready}, 32'd1);

    // new_note held high: second offer only taken after returning to IDLE.
    note = 6'd2; duration = 6'd1; new_note = 1'b1;
    tick();
    note = 6'd3; duration = 6'd5;
    tick();
    check("t5_play_ready", {31'd0, player_ready}, 32'd0);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    check("t5_first_done", {31'd0, note_done}, 32'd1);
    tick();
    check("t5_idle_ready", {31'd0, player_ready}, 32'd1);
    tick();
    new_note = 1'b0;
    check("t5_reload_ready", {31'd0, player_ready}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      beat = 1'b1;
      tick();
      check("t5_second_early", {31'd0, note_done}, 32'd0);
    end
    tick();
    beat = 1'b0;
    check("t5_second_done", {31'd0, note_done}, 32'd1);
    tick();
    check("t5_end_ready", {31'd0, player_ready}, 32'd1);

    // Reset in the middle of PLAY with coincident beat and request.
    note = 6'd1; duration = 6'd4; new_note = 1'b1;
    tick();
    new_note = 1'b0;
    tick();
    generate_next_sample = 1'b1;
    tick();
    check("t6_pre_sout", {16'd0, sample_out}, {16'd0, POS});
    reset = 1'b1; beat = 1'b1;
    tick();
    reset = 1'b0; beat = 1'b0; generate_next_sample = 1'b0;
    check("t6_rst_ready", {31'd0, player_ready}, 32'd1);
    check("t6_rst_done",  {31'd0, note_done}, 32'd0);
    check("t6_rst_srdy",  {31'd0, sample_ready}, 32'd0);
    check("t6_rst_sout",  {16'd0, sample_out}, 32'd0);
    tick();
    check("t6_after_ready", {31'd0, player_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 play  input  1  high = playback running; low = paused.
REQ-005 beat  input  1  one-cycle beat tick, counted only while play=1.
REQ-006 new_note  input  1  note offer from upstream song sequencer; transfer occurs when new_note & player_ready.
REQ-007 note  input  6  note index; 0 = rest (silence).
REQ-008 duration  input  6  note length in beats.
REQ-009 generate_next_sample  input  1  one-cycle request for the next audio sample.
REQ-010 player_ready  output  1  high only in IDLE; player can accept a note.
REQ-011 note_done  output  1  one-cycle pulse when the current note's duration expires.
REQ-012 sample_out  output  16  signed square-wave sample.
REQ-013 sample_ready  output  1  one-cycle pulse; sample_out valid.

Function
REQ-014 SHALL implement states IDLE, LOAD, PLAY, DONE.
- IDLE -> LOAD on new_note & player_ready; note and duration captured that cycle.
- LOAD -> PLAY after exactly 1 cycle, allowing for the registered step-size lookup; LOAD -> DONE if captured duration = 0.
- PLAY -> DONE on the beat (with play=1) that decrements the remaining count from 1 to 0.
- DONE -> IDLE after 1 cycle; note_done=1 only in DONE.
REQ-015 SHALL keep player_ready combinational from state (IDLE only), independent of new_note; new_note while not ready SHALL be ignored and not queued.
REQ-016 SHALL keep remaining-beat counter 6-bit, loaded with duration; decrement only on beat & play in PLAY; no wrap below 0.
REQ-017 SHALL freeze beat counting and phase accumulation while play=0; state and counters held.
REQ-018 SHALL keep a 20-bit phase accumulator, cleared on every note capture; on generate_next_sample & play in PLAY, add step_size (modulo 2^20 wrap).
REQ-019 sample_out SHALL be +16'sh3FFF when accumulator bit 19 = 0, -16'sh3FFF when it = 1, and 0 when note = 0 or state != PLAY or play = 0.
REQ-020 sample_ready SHALL pulse exactly 1 cycle after every generate_next_sample, in every state, with sample_out computed from the updated accumulator.
REQ-021 Simultaneous beat and generate_next_sample SHALL both be honoured in the same cycle.
REQ-022 On a final beat with a coincident sample request, the sample SHALL still be generated; the following cycle is DONE.
REQ-023 note 0 SHALL follow the full timing (LOAD/PLAY/DONE) with silent output.

Reset
REQ-024 reset SHALL force state IDLE, counter 0, accumulator 0, captured note/duration 0, and take priority over all other inputs, including mid-note.
REQ-025 Reset values SHALL be: player_ready=1 from the first post-reset cycle, note_done=0, sample_ready=0, sample_out=0.

Structure
REQ-026 State encodings, amplitude constant (16'sh3FFF) and accumulator width (20) SHALL live in the shared song-player package or define file, used by the upstream sequencer as well.
REQ-027 A single sub-module frequency_rom SHALL map the 6-bit note to a 20-bit step_size with a registered output (1-cycle latency), returning 0 for note 0.
REQ-028 All flops SHALL use the codebase's dffr reset-flop primitive.

Verification
REQ-029 reset, then note=6'd1, duration=6'd2, new_note=1, play=1 -> player_ready drops the next cycle, LOAD lasts 1 cycle, note_done pulses 1 cycle after the 2nd beat, then player_ready=1.
REQ-030 duration=0 offer -> IDLE, LOAD, DONE (note_done=1), IDLE in consecutive cycles; no sample_out nonzero.
REQ-031 In PLAY, play=0 for 10 beats and 5 sample requests -> counter unchanged, sample_out=0, sample_ready still pulses 5 times; resuming completes after the remaining beats.
REQ-032 Known step, e.g. 20'h80000 -> the sample sign alternates +3FFF/-3FFF on each request; an accumulator wrap past 2^20 is observed without glitch.
REQ-033 new_note held high during PLAY -> ignored; accepted only on return to IDLE.
REQ-034 reset asserted mid-PLAY with beat and generate_next_sample coincident -> next cycle IDLE, all outputs at reset values.
